mat_sram_loader: RTL and testbench

- Upstream fill stage for the PE array datapath.
- Accepts a 32-bit valid/ready word stream from the host/DMA. Packs ARRAY_SIZE weight words into one SRAM_DATA_WIDTH row and writes it into the weight SRAM. Then writes vector words into the vector SRAM.
- Signals load_done when both SRAMs hold a complete job, so the controller can raise start_processing.

---
 rtl/mat_sram_loader_pkg.sv | 30 +++
 rtl/mat_sram_loader_word_row_packer.sv | 63 ++++++
 rtl/mat_sram_loader.sv | 167 ++++++++++++++++
 tb/tb_mat_sram_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_sram_loader_pkg.sv
// Shared definitions for the weight/vector SRAM fill path.
// Holds array geometry, SRAM depth/address width, the loader state encoding
// and the job-length clamp used when a job is started.
package mat_sram_loader_pkg;

  localparam int ARRAY_SIZE      = 32;
  localparam int DATA_WIDTH      = 32;
  localparam int SRAM_DATA_WIDTH = ARRAY_SIZE * DATA_WIDTH;
  localparam int K_ACCUM_DEPTH   = 64;
  localparam int ADDR_W          = $clog2(K_ACCUM_DEPTH);
  // Row counts need one extra bit so that K_ACCUM_DEPTH itself is representable.
  localparam int ROW_W           = ADDR_W + 1;
  localparam int WIDX_W          = $clog2(ARRAY_SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_V = 2'd2,
    DONE   = 2'd3
  } load_state_e;

  // A zero or oversized request means "fill the whole SRAM".
  function automatic logic [ROW_W-1:0] clamp_rows(input logic [ROW_W-1:0] cfg);
    logic [ROW_W-1:0] r;
    if ((cfg == '0) || (cfg > ROW_W'(K_ACCUM_DEPTH))) r = ROW_W'(K_ACCUM_DEPTH);
    else                                               r = cfg;
    return r;
  endfunction

endpackage

// File: rtl/mat_sram_loader_word_row_packer.sv
// Packs consecutive stream words into one weight SRAM row.
// Ports:
//   clk, srstn   clock, asynchronous active-low reset
//   clr          drop the partial row and restart at word 0 (abort / new job)
//   push         a word is accepted this cycle
//   word         accepted word
//   row_last     combinational: this push completes a row
//   row_data     registered copy of the last completed row (holds between rows)
module word_row_packer
  import mat_sram_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       srstn,
  input  logic                       clr,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      word,
  output logic                       row_last,
  output logic [SRAM_DATA_WIDTH-1:0] row_data
);

  logic [WIDX_W-1:0]          idx_q,  idx_d;
  logic [SRAM_DATA_WIDTH-1:0] pack_q, pack_d;
  logic [SRAM_DATA_WIDTH-1:0] row_q,  row_d;

  assign row_last = push && (idx_q == WIDX_W'(ARRAY_SIZE - 1));
  assign row_data = row_q;

  always_comb begin
    idx_d  = idx_q;
    pack_d = pack_q;
    row_d  = row_q;
    if (clr) begin
      // Clear also blocks the row copy, so an aborted final word never
      // reaches the write data register.
      idx_d  = '0;
      pack_d = '0;
    end else if (push) begin
      if (row_last) begin
        // The last word bypasses the pack register straight into the row copy.
        row_d = pack_q;
        row_d[(ARRAY_SIZE-1)*DATA_WIDTH +: DATA_WIDTH] = word;
        idx_d  = '0;
        pack_d = '0;
      end else begin
        pack_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = word;
        idx_d = idx_q + WIDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      idx_q  <= '0;
      pack_q <= '0;
      row_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      pack_q <= pack_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/mat_sram_loader.sv
// Fill stage for the PE array: takes a valid/ready word stream, writes
// rows_q packed weight rows into the weight SRAM, then rows_q words into
// the vector SRAM, and pulses load_done when the job is complete.
// Ports:
//   clk, srstn                 clock, asynchronous active-low reset
//   load_start, cfg_rows       start a job of cfg_rows rows (IDLE only)
//   load_abort                 synchronous cancel of the current job
//   s_valid, s_data, s_ready   input word stream
//   w_csb/w_wsb/w_waddr/w_wdata  weight SRAM write port (strobes active low)
//   v_csb/v_wsb/v_waddr/v_wdata  vector SRAM write port (strobes active low)
//   busy                       job in progress
//   load_done                  one-cycle completion pulse
module mat_sram_loader
  import mat_sram_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       srstn,
  input  logic                       load_start,
  input  logic [ADDR_W:0]            cfg_rows,
  input  logic                       load_abort,
  input  logic                       s_valid,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       s_ready,
  output logic                       w_csb,
  output logic                       w_wsb,
  output logic [ADDR_W-1:0]          w_waddr,
  output logic [SRAM_DATA_WIDTH-1:0] w_wdata,
  output logic                       v_csb,
  output logic                       v_wsb,
  output logic [ADDR_W-1:0]          v_waddr,
  output logic [DATA_WIDTH-1:0]      v_wdata,
  output logic                       busy,
  output logic                       load_done
);

  load_state_e           state_q, state_d;
  logic [ROW_W-1:0]      rows_q, rows_d;
  logic [ROW_W-1:0]      w_row_q, w_row_d;
  logic [ROW_W-1:0]      v_cnt_q, v_cnt_d;
  logic                  w_wr_q, w_wr_d;
  logic [ADDR_W-1:0]     w_waddr_q, w_waddr_d;
  logic                  v_wr_q, v_wr_d;
  logic [ADDR_W-1:0]     v_waddr_q, v_waddr_d;
  logic [DATA_WIDTH-1:0] v_wdata_q, v_wdata_d;
  logic                  load_done_q, load_done_d;

  logic                  accept;
  logic                  job_start;
  logic                  pk_clr;
  logic                  pk_push;
  logic                  row_last;
  logic [ROW_W-1:0]      w_row_inc;
  logic [ROW_W-1:0]      v_cnt_inc;

  assign s_ready   = (state_q == LOAD_W) || (state_q == LOAD_V);
  assign busy      = (state_q != IDLE);
  assign accept    = s_valid && s_ready;
  assign job_start = (state_q == IDLE) && load_start && !load_abort;
  assign pk_clr    = load_abort || job_start;
  assign pk_push   = accept && (state_q == LOAD_W);
  assign w_row_inc = w_row_q + ROW_W'(1);
  assign v_cnt_inc = v_cnt_q + ROW_W'(1);

  word_row_packer u_packer (
    .clk      (clk),
    .srstn    (srstn),
    .clr      (pk_clr),
    .push     (pk_push),
    .word     (s_data),
    .row_last (row_last),
    .row_data (w_wdata)
  );

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    w_row_d     = w_row_q;
    v_cnt_d     = v_cnt_q;
    w_wr_d      = 1'b0;
    w_waddr_d   = w_waddr_q;
    v_wr_d      = 1'b0;
    v_waddr_d   = v_waddr_q;
    v_wdata_d   = v_wdata_q;
    load_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (job_start) begin
          rows_d  = clamp_rows(cfg_rows);
          w_row_d = '0;
          v_cnt_d = '0;
          state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        if (row_last) begin
          w_wr_d    = 1'b1;
          w_waddr_d = w_row_q[ADDR_W-1:0];
          w_row_d   = w_row_inc;
          if (w_row_inc == rows_q) state_d = LOAD_V;
        end
      end
      LOAD_V: begin
        if (accept) begin
          v_wr_d    = 1'b1;
          v_waddr_d = v_cnt_q[ADDR_W-1:0];
          v_wdata_d = s_data;
          v_cnt_d   = v_cnt_inc;
          if (v_cnt_inc == rows_q) state_d = DONE;
        end
      end
      DONE: begin
        load_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort discards any write this cycle's acceptance would have scheduled;
    // write ports keep presenting the previous address/data.
    if (load_abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      w_wr_d      = 1'b0;
      w_waddr_d   = w_waddr_q;
      v_wr_d      = 1'b0;
      v_waddr_d   = v_waddr_q;
      v_wdata_d   = v_wdata_q;
      load_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      w_row_q     <= '0;
      v_cnt_q     <= '0;
      w_wr_q      <= 1'b0;
      w_waddr_q   <= '0;
      v_wr_q      <= 1'b0;
      v_waddr_q   <= '0;
      v_wdata_q   <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      w_row_q     <= w_row_d;
      v_cnt_q     <= v_cnt_d;
      w_wr_q      <= w_wr_d;
      w_waddr_q   <= w_waddr_d;
      v_wr_q      <= v_wr_d;
      v_waddr_q   <= v_waddr_d;
      v_wdata_q   <= v_wdata_d;
      load_done_q <= load_done_d;
    end
  end

  assign w_csb     = ~w_wr_q;
  assign w_wsb     = ~w_wr_q;
  assign w_waddr   = w_waddr_q;
  assign v_csb     = ~v_wr_q;
  assign v_wsb     = ~v_wr_q;
  assign v_waddr   = v_waddr_q;
  assign v_wdata   = v_wdata_q;
  assign load_done = load_done_q;

endmodule

// File: tb/tb_mat_sram_loader.sv
// Scoreboard bench for mat_sram_loader: the stimulus side pushes expected
// SRAM writes / completion pulses (with their cycle) into queues, and a
// monitor on the falling edge pops and compares whenever the DUT writes.
module tb_mat_sram_loader;
  import mat_sram_loader_pkg::*;

  logic                       clk = 1'b0;
  logic                       srstn = 1'b0;
  logic                       load_start = 1'b0;
  logic [ADDR_W:0]            cfg_rows = '0;
  logic                       load_abort = 1'b0;
  logic                       s_valid = 1'b0;
  logic [DATA_WIDTH-1:0]      s_data = '0;
  logic                       s_ready;
  logic                       w_csb, w_wsb, v_csb, v_wsb;
  logic [ADDR_W-1:0]          w_waddr, v_waddr;
  logic [SRAM_DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0]      v_wdata;
  logic                       busy, load_done;

  mat_sram_loader dut (
    .clk(clk), .srstn(srstn), .load_start(load_start), .cfg_rows(cfg_rows),
    .load_abort(load_abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .w_csb(w_csb), .w_wsb(w_wsb), .w_waddr(w_waddr), .w_wdata(w_wdata),
    .v_csb(v_csb), .v_wsb(v_wsb), .v_waddr(v_waddr), .v_wdata(v_wdata),
    .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { int cyc; int addr; logic [SRAM_DATA_WIDTH-1:0] data; } w_exp_t;
  typedef struct { int cyc; int addr; logic [DATA_WIDTH-1:0] data; } v_exp_t;
  w_exp_t wq[$];
  v_exp_t vq[$];
  int     dq[$];
  int     w_seen = 0, v_seen = 0, d_seen = 0, acc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_row(input string name, input logic [SRAM_DATA_WIDTH-1:0] act,
                           input logic [SRAM_DATA_WIDTH-1:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int j = ARRAY_SIZE - 1; j >= 0; j--)
        if (act[j*DATA_WIDTH +: DATA_WIDTH] !== exp[j*DATA_WIDTH +: DATA_WIDTH]) bad = j;
      $display("FAIL %s: word %0d got %0h expected %0h (cycle %0d)", name, bad,
               act[bad*DATA_WIDTH +: DATA_WIDTH], exp[bad*DATA_WIDTH +: DATA_WIDTH], cyc);
    end
  endtask

  // Monitor: every write strobe / done pulse must match the head of its queue.
  w_exp_t we;
  v_exp_t ve;
  int     de;
  always @(negedge clk) begin
    if (srstn) begin
      if (!w_csb || !w_wsb) begin
        w_seen++;
        if (wq.size() == 0) begin
          errors++; checks++;
          $display("FAIL w_unexpected: got write addr %0d expected none (cycle %0d)", w_waddr, cyc);
        end else begin
          we = wq.pop_front();
          check("w_strobes", {w_csb, w_wsb}, 2'b00);
          check("w_cycle", cyc, we.cyc);
          check("w_addr", w_waddr, we.addr);
          check_row("w_data", w_wdata, we.data);
        end
      end
      if (!v_csb || !v_wsb) begin
        v_seen++;
        if (vq.size() == 0) begin
          errors++; checks++;
          $display("FAIL v_unexpected: got write addr %0d expected none (cycle %0d)", v_waddr, cyc);
        end else begin
          ve = vq.pop_front();
          check("v_strobes", {v_csb, v_wsb}, 2'b00);
          check("v_cycle", cyc, ve.cyc);
          check("v_addr", v_waddr, ve.addr);
          check("v_data", v_wdata, ve.data);
        end
      end
      if (load_done) begin
        d_seen++;
        if (dq.size() == 0) begin
          errors++; checks++;
          $display("FAIL done_unexpected: got load_done expected none (cycle %0d)", cyc);
        end else begin
          de = dq.pop_front();
          check("done_cycle", cyc, de);
          check("busy_at_done", busy, 1'b0);
        end
      end
    end
  end

  task automatic start_job(input int cfg);
    cfg_rows   = (ADDR_W+1)'(cfg);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  // Offer one word; returns the cycle on whose closing edge it was accepted.
  task automatic send(input int d, input bit abort, input bit poke, output int acc);
    int t;
    s_valid = 1'b1;
    s_data  = DATA_WIDTH'(d);
    load_abort = abort;
    if (poke) begin
      load_start = 1'b1;
      cfg_rows   = (ADDR_W+1)'(3);
    end
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      errors++; checks++;
      $display("FAIL s_ready_timeout: got s_ready=0 expected 1 (cycle %0d)", cyc);
    end
    acc = cyc;
    acc_cnt++;
    @(posedge clk); #1;
    s_valid    = 1'b0;
    load_abort = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((wq.size() + vq.size() + dq.size() > 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_w", wq.size(), 0);
    check("drain_v", vq.size(), 0);
    check("drain_done", dq.size(), 0);
  endtask

  // n_vec < 0: full job with done; otherwise stop after n_vec vector words.
  task automatic run_job(input int cfg, input int rows, input int base, input bit gap,
                         input int poke_idx, input int n_vec);
    logic [SRAM_DATA_WIDTH-1:0] row;
    int acc, nv, vd;
    int w0, v0, d0, a0;
    w0 = w_seen; v0 = v_seen; d0 = d_seen; a0 = acc_cnt;
    nv = (n_vec < 0) ? rows : n_vec;
    start_job(cfg);
    row = '0;
    for (int i = 0; i < rows * ARRAY_SIZE; i++) begin
      send(base + i, 1'b0, (i == poke_idx), acc);
      row[(i % ARRAY_SIZE)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(base + i);
      if (i % ARRAY_SIZE == ARRAY_SIZE - 1) begin
        wq.push_back(w_exp_t'{acc + 1, i / ARRAY_SIZE, row});
        row = '0;
      end
      if (gap) idle_cycle();
    end
    for (int k = 0; k < nv; k++) begin
      vd = base + rows * ARRAY_SIZE + k;
      send(vd, 1'b0, 1'b0, acc);
      vq.push_back(v_exp_t'{acc + 1, k, DATA_WIDTH'(vd)});
      if (k == rows - 1) dq.push_back(acc + 2);
      if (gap) idle_cycle();
    end
    if (n_vec < 0) begin
      drain();
      check("job_w_writes", w_seen - w0, rows);
      check("job_v_writes", v_seen - v0, rows);
      check("job_done_pulses", d_seen - d0, 1);
      check("job_words", acc_cnt - a0, rows * (ARRAY_SIZE + 1));
      check("idle_after_job", {busy, s_ready}, 2'b00);
    end
  endtask

  // Single-row job cancelled on word abort_idx; nothing must be written.
  task automatic abort_job(input int abort_idx, input int base);
    int acc, w0, d0;
    w0 = w_seen; d0 = d_seen;
    start_job(1);
    for (int i = 0; i <= abort_idx; i++) send(base + i, (i == abort_idx), 1'b0, acc);
    check("abort_idle", {busy, s_ready}, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_w", w_seen - w0, 0);
    check("abort_no_done", d_seen - d0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_strobes", {w_csb, w_wsb, v_csb, v_wsb}, 4'b1111);
    check("rst_waddr", w_waddr, 0);
    check("rst_vaddr", v_waddr, 0);
    check("rst_wdata_lo", w_wdata[63:0], 0);
    check("rst_vdata", v_wdata, 0);
    check("rst_ctrl", {s_ready, busy, load_done}, 3'b000);
    repeat (3) @(posedge clk);
    #1 srstn = 1'b1;
    idle_cycle();

    // Start and abort together in IDLE: abort wins
    load_start = 1'b1; load_abort = 1'b1; cfg_rows = 1;
    idle_cycle();
    load_start = 1'b0; load_abort = 1'b0;
    check("start_abort_idle", {busy, s_ready}, 2'b00);

    // Two rows, values = index
    run_job(2, 2, 0, 1'b0, -1, -1);
    check("hold_w_lo", w_wdata[31:0], 32);
    check("hold_w_hi", w_wdata[1023:992], 63);
    check("hold_v", v_wdata, 65);
    check("hold_strobes", {w_csb, w_wsb, v_csb, v_wsb}, 4'b1111);

    // cfg_rows=0 means the full depth
    run_job(0, K_ACCUM_DEPTH, 1000, 1'b0, -1, -1);

    // One row with s_valid gaps
    run_job(1, 1, 0, 1'b1, -1, -1);

    // Abort on the final word of the row, then a clean job
    abort_job(ARRAY_SIZE - 1, 500);
    run_job(1, 1, 700, 1'b0, -1, -1);

    // Abort mid-row: the word counter must restart for the next job
    abort_job(10, 800);
    run_job(1, 1, 900, 1'b0, -1, -1);

    // Reset while in LOAD_V, right during a vector write
    run_job(2, 2, 1200, 1'b0, -1, 1);
    @(negedge clk);
    #2 srstn = 1'b0;
    #1;
    check("mid_rst_strobes", {w_csb, w_wsb, v_csb, v_wsb}, 4'b1111);
    check("mid_rst_ctrl", {s_ready, busy, load_done}, 3'b000);
    repeat (2) @(posedge clk);
    #1 srstn = 1'b1;
    check("mid_rst_vq", vq.size(), 0);
    run_job(1, 1, 1400, 1'b0, -1, -1);

    // load_start while busy must not re-latch cfg_rows
    run_job(1, 1, 2000, 1'b0, 5, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
